// File: rtl/reset_sequencer.sv
// Staged reset release: synchronises board reset deassertion, then releases
// NUM_STAGES active-low reset domains one at a time, STAGE_GAP cycles apart.
`timescale 1ns/1ps
module reset_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int STAGE_GAP  = 4,
  parameter int SYNC_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_rst,
  input  logic                  hold,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  seq_done,
  output logic                  busy
);

  localparam int CW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int IW = $clog2(NUM_STAGES + 1);

  typedef enum logic [1:0] {WAIT = 2'd0, SEQ = 2'd1, DONE = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [NUM_STAGES-1:0] rst_nxt;
  logic                  done_nxt;
  logic                  busy_nxt;
  logic [SYNC_DEPTH-1:0] sync;
  logic                  sync_rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[SYNC_DEPTH-2:0], 1'b1};
  end

  assign sync_rst_n = sync[SYNC_DEPTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= WAIT;
      cnt       <= '0;
      idx       <= '0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      rst_n_out <= rst_nxt;
      seq_done  <= done_nxt;
      busy      <= busy_nxt;
    end
  end

  // Outputs are computed one edge ahead so every output comes straight from a flop.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    rst_nxt   = rst_n_out;
    done_nxt  = seq_done;
    busy_nxt  = busy;
    if (sw_rst) begin
      state_nxt = WAIT;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      rst_nxt   = '0;
      done_nxt  = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (sync_rst_n) begin
            state_nxt = SEQ;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            busy_nxt  = 1'b1;
          end
        end
        SEQ: begin
          if (!hold) begin
            if (cnt == CW'(STAGE_GAP - 1)) begin
              cnt_nxt = '0;
              idx_nxt = idx + 1'b1;
              for (int k = 0; k < NUM_STAGES; k++) begin
                if (idx == IW'(k)) rst_nxt[k] = 1'b1;
              end
              if (idx == IW'(NUM_STAGES - 1)) begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
              end
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        DONE: begin
          rst_nxt  = '1;
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
        end
        default: begin
          state_nxt = WAIT;
        end
      endcase
    end
  end

endmodule
